// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation codes, result record and default widths.
package alu_pkg;
  localparam int DATA_W_DEFAULT = 32;
  localparam int TAG_W_DEFAULT = 5;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_BNE = 4'b0011,
    ALU_OR  = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_BGE = 4'b0110,
    ALU_BLT = 4'b0111,
    ALU_BEQ = 4'b1000
  } alu_op_t;
  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] result;
    logic                      zero;
    logic                      branch_taken;
    logic                      illegal_op;
    logic [TAG_W_DEFAULT-1:0]  tag;
  } alu_res_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational decode of an ALU operation into result, zero, branch and illegal flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [3:0]        operation,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              branch_taken,
  output logic              illegal_op
);
  logic [DATA_W-1:0] diff;
  logic lt;
  assign diff = a - b;
  assign lt = $signed(a) < $signed(b);
  always_comb begin
    result = '0;
    branch_taken = 1'b0;
    illegal_op = 1'b0;
    case (alu_op_t'(operation))
      ALU_AND: result = a & b;
      ALU_SUB: result = diff;
      ALU_ADD: result = a + b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_BNE: begin result = diff; branch_taken = a != b; end
      ALU_BLT: begin result = diff; branch_taken = lt; end
      ALU_BGE: begin result = diff; branch_taken = !lt; end
      ALU_BEQ: begin result = diff; branch_taken = a == b; end
      default: illegal_op = 1'b1;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage ALU with valid/ready issue, 2-entry output queue and flush.
module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        operation,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              branch_taken,
  output logic              illegal_op,
  output logic [TAG_W-1:0]  out_tag
);
  logic [DATA_W-1:0] c_result;
  logic c_zero, c_taken, c_illegal;
  logic [DATA_W-1:0] res_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [DEPTH-1:0] zero_q, br_q, ill_q;
  logic head, tail, push, pop;
  logic [1:0] count;
  alu_core #(.DATA_W(DATA_W)) u_core (
    .operation(operation),
    .a(src_a),
    .b(src_b),
    .result(c_result),
    .zero(c_zero),
    .branch_taken(c_taken),
    .illegal_op(c_illegal)
  );
  assign in_ready = count < 2'd2;
  assign out_valid = count != 2'd0;
  assign push = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready && !flush;
  assign result = res_q[head];
  assign zero = zero_q[head];
  assign branch_taken = br_q[head];
  assign illegal_op = ill_q[head];
  assign out_tag = tag_q[head];
  // Reset also clears stored entries so the head fields read as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      head <= 1'b0;
      tail <= 1'b0;
      res_q <= '{default: '0};
      tag_q <= '{default: '0};
      zero_q <= '0;
      br_q <= '0;
      ill_q <= '0;
    end else if (flush) begin
      count <= '0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      if (push) begin
        res_q[tail] <= c_result;
        tag_q[tail] <= in_tag;
        zero_q[tail] <= c_zero;
        br_q[tail] <= c_taken;
        ill_q[tail] <= c_illegal;
        tail <= ~tail;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
- Execute-stage consumer of the 4-bit ALU Operation code produced by the ALU controller.
- Accepts one operation per cycle through a valid/ready handshake and computes the data result, zero flag and branch decision.
- Buffers results in a 2-entry output queue so the EX/MEM side can stall without a combinational path back to the issue side.
- Supports a pipeline flush that discards all in-flight work.

Parameters:
- DATA_W, 32, operand/result width in bits.
- TAG_W, 5, width of the destination-register tag carried alongside each operation.
- DEPTH, 2, output queue entries; fixed at 2, other values unsupported.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  issue side presents an operation.
- in_ready  output  1  unit can accept; registered, equals (count < 2).
- operation  input  4  ALU operation code.
- src_a  input  DATA_W  operand A.
- src_b  input  DATA_W  operand B.
- in_tag  input  TAG_W  destination tag, passed through unchanged.
- flush  input  1  discard all queued and same-cycle input.
- out_valid  output  1  head entry holds a valid result.
- out_ready  input  1  consumer accepts the head entry.
- result  output  DATA_W  head result.
- zero  output  1  head result == 0.
- branch_taken  output  1  head branch decision.
- illegal_op  output  1  head operation code was unsupported.
- out_tag  output  TAG_W  head tag.

Behaviour:
- Reset values: count=0, in_ready=1, out_valid=0; result, zero, branch_taken, illegal_op and out_tag all 0.
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush.
- Latency: an operation pushed at edge T is visible at the head after edge T (out_valid=1 in cycle T+1) if the queue was empty.
- Throughput is 1/cycle when out_ready is held high.
- in_ready depends only on registered count; no combinational in_ready/out_ready path.
- count=2: in_ready=0, input ignored even if a pop occurs the same cycle; in_ready rises the cycle after the pop.
- count=1 with simultaneous push and pop: count stays 1, new entry becomes head. FIFO order is always preserved.
- count=0: out_valid=0; head output fields hold their last value but are don't-care.
- flush: both entries invalidated, count=0 and in_ready=1 next cycle. A same-cycle push and pop are both suppressed. flush has priority over everything except reset.
- Reset asserted mid-operation behaves like flush plus clearing all output fields to 0.
- Arithmetic: ADD and SUB wrap modulo 2^DATA_W, with no overflow flag.
- Operation codes:
  - 0000 AND: result = a & b.
  - 0001 SUB: result = a - b.
  - 0010 ADD: result = a + b.
  - 0100 OR: result = a | b.
  - 0101 XOR: result = a ^ b.
  - 0011 BNE: taken = a != b.
  - 0111 BLT: taken = signed(a) < signed(b).
  - 0110 BGE: taken = signed(a) >= signed(b).
  - 1000 BEQ: taken = a == b.
- For branch codes, result = a - b. branch_taken=0 for all non-branch codes.
- Codes 1001-1111: result=0, zero=1, branch_taken=0, illegal_op=1. The entry still flows through the queue normally.
- zero is computed from the final result, before enqueue.

Decomposition:
- Package alu_pkg holds:
  - typedef alu_op_t, a 4-bit enum with ALU_AND, ALU_SUB, ALU_ADD, ALU_BNE, ALU_OR, ALU_XOR, ALU_BGE, ALU_BLT, ALU_BEQ;
  - the struct alu_res_t {result, zero, branch_taken, illegal_op, tag};
  - localparam DATA_W_DEFAULT.
- Sub-module alu_core: purely combinational (operation, a, b) -> alu_res_t fields.
- The top level holds the 2-entry queue: head/tail pointer bits, count and handshake.

Test Plan:
- ADD a=0xFFFFFFFF, b=1, tag=7, out_ready=1 -> next cycle out_valid=1, result=0, zero=1, branch_taken=0, out_tag=7.
- BLT a=0xFFFFFFFE (-2), b=1 -> branch_taken=1, result=0xFFFFFFFD; BGE same operands -> branch_taken=0. BEQ a=b=5 -> taken=1, zero=1.
- out_ready=0, push 3 ops back-to-back (ADD 1+2, SUB 9-4, XOR 6^3) -> in_ready=0 after 2 accepted, third held. Raise out_ready -> outputs 3, 5, 5 in order, third accepted the cycle after in_ready returns to 1.
- count=1 with in_valid=1 and out_ready=1 every cycle for 8 ops -> count stays 1, one result per cycle, no drops or duplicates.
- count=2 with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the flushed input never appears.
- operation=1011 a=0x12, b=0x34 -> illegal_op=1, result=0, zero=1. Reset mid-stream with count=2 -> next cycle all outputs 0, in_ready=1.
